pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit that produces the enable/clear controls consumed by the IF/ID and ID/EX stage registers and the PC.
- Also gates the EX/MEM and MEM/WB registers.
- Detects load-use hazards, redirects on taken branch/jump resolved in EX, freezes the whole pipe while data memory is not ready, and inserts start-up bubbles after reset.
- Sits beside the 5-stage RV32I pipeline datapath; purely a control block.

Parameters:
- RESET_BUBBLES, 2: cycles after reset release during which PC is held and IF/ID, ID/EX are cleared.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before mem_err is raised. Must fit in an 8-bit counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 field of instruction in ID
- id_rs2  in  5  rs2 field of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_memread  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_req  in  1  MEM stage issues a data-memory access this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID enable
- ifid_clear  out  1  IF/ID clear (bubble)
- idex_en  out  1  ID/EX enable
- idex_clear  out  1  ID/EX clear (bubble)
- exmem_en  out  1  EX/MEM enable
- memwb_en  out  1  MEM/WB enable
- mem_err  out  1  sticky memory-timeout flag
- state_o  out  2  current state, for debug

Behaviour:
- Reset: synchronous on clk when rst=1.
  - state <= BOOT, bubble counter <= RESET_BUBBLES, wait counter <= 0, mem_err <= 0.
  - While rst=1, outputs are pc_en=0, ifid_en=1, ifid_clear=1, idex_en=1, idex_clear=1, exmem_en=1, memwb_en=1.
- States: BOOT=0, RUN=1, MEM_WAIT=2. Value 3 is illegal and recovers to RUN next cycle with RUN outputs.
- BOOT:
  - Outputs pc_en=0, ifid_clear=1, idex_clear=1, all enables 1.
  - The bubble counter decrements each cycle; at 1 → RUN.
  - If RESET_BUBBLES=0, go directly to RUN the cycle after reset.
- RUN, with outputs evaluated combinationally in this priority order:
  1. mem_req=1 and mem_ready=0:
     - All enables 0 and all clears 0 (full freeze).
     - Next state MEM_WAIT; wait counter <= 1.
  2. ex_redirect=1:
     - pc_en=1, ifid_clear=1, idex_clear=1, all enables 1.
     - 2-cycle penalty.
     - Redirect overrides a simultaneous load-use hazard.
  3. Load-use hazard, defined as ex_memread=1 and ex_rd≠0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)):
     - pc_en=0, ifid_en=0, idex_clear=1, idex_en=1, exmem_en=1, memwb_en=1.
     - Exactly 1 bubble.
  4. Otherwise all enables 1, clears 0.
- MEM_WAIT:
  - Full freeze as in RUN item 1. The wait counter increments each cycle and saturates at MEM_TIMEOUT.
  - When mem_ready=1: freeze released that same cycle. Outputs follow RUN rules 2–4 with the frozen EX inputs, and next state is RUN.
  - When wait counter == MEM_TIMEOUT and mem_ready=0: mem_err <= 1. mem_err is sticky until rst.
  - Stay in MEM_WAIT.
- Clear dominates enable in the consuming registers; this block never asserts a clear for a register whose enable it deasserts, except BOOT.
- No input is registered; the outputs settle in the same cycle as the input change. Only state, the counters and mem_err are flops.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three outputs, each 32-bit, wrapping at 2^32:
  - perf_stall: count of cycles with a load-use bubble.
  - perf_flush: count of redirect cycles.
  - perf_memwait: count of freeze cycles.
- All three counters reset to 0 on rst and do not count during BOOT.
- When not defined, the ports and logic are absent.

Test Plan:
- Reset release with RESET_BUBBLES=2 → 2 cycles of pc_en=0, ifid_clear=1, idex_clear=1, then state_o=1 with all enables 1.
- ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle of pc_en=0, ifid_en=0, idex_clear=1. Repeating with ex_rd=0 gives no stall.
- ex_redirect=1 together with the above load-use match → pc_en=1, ifid_clear=1, idex_clear=1, ifid_en=1; no stall.
- mem_req=1 with mem_ready low for 3 cycles then high → 3 cycles of all enables 0, release on the ready cycle, state_o goes 1→2→2→2→1.
- MEM_TIMEOUT=4 with mem_ready held 0 → mem_err rises after 4 wait cycles and stays 1 after mem_ready=1, cleared only by rst.
- With HAZARD_PERF_CNT_EN: 2 load-use bubbles, 1 redirect, 3 wait cycles → perf_stall=2, perf_flush=1, perf_memwait=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Control interface between the RV32I pipeline datapath (master) and the hazard control unit (slave).
// Define HAZARD_PERF_CNT_EN to add the performance counter outputs.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_clear;
    logic        idex_en;
    logic        idex_clear;
    logic        exmem_en;
    logic        memwb_en;
    logic        mem_err;
    logic [1:0]  state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
    logic [31:0] perf_memwait;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
               ex_redirect, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en,
               memwb_en, mem_err, state_o
`ifdef HAZARD_PERF_CNT_EN
        , input perf_stall, perf_flush, perf_memwait
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
               ex_redirect, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en,
               memwb_en, mem_err, state_o
`ifdef HAZARD_PERF_CNT_EN
        , output perf_stall, perf_flush, perf_memwait
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: start-up bubbles, load-use stall, EX redirect flush, data-memory freeze.
// Define HAZARD_PERF_CNT_EN to add 32-bit stall/flush/memwait performance counters.
module pipe_hazard_ctrl #(
    parameter int RESET_BUBBLES = 2,
    parameter int MEM_TIMEOUT   = 255
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [7:0] BUB_INIT = 8'(RESET_BUBBLES);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] bub_cnt_q, bub_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic load_use;
    logic mem_stall;
    logic boot;
    logic freeze;
    logic resolve;
    logic run_redirect;
    logic run_stall;

    logic pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, memwb_en;

    assign load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign mem_stall = bus.mem_req && !bus.mem_ready;

    // resolve means the redirect / load-use / normal priority chain decides this cycle
    always_comb begin
        state_d    = state_q;
        bub_cnt_d  = bub_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        boot       = 1'b0;
        freeze     = 1'b0;
        resolve    = 1'b0;
        case (state_q)
            BOOT: begin
                boot = 1'b1;
                if (bub_cnt_q != 8'd0) bub_cnt_d = bub_cnt_q - 8'd1;
                if (bub_cnt_q <= 8'd1) state_d = RUN;
            end
            RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    freeze = 1'b1;
                    if (wait_cnt_q >= WAIT_MAX) begin
                        wait_cnt_d = WAIT_MAX;
                        mem_err_d  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    resolve    = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d = RUN;
                if (mem_stall) freeze = 1'b1;
                else           resolve = 1'b1;
            end
        endcase
    end

    assign run_redirect = resolve && bus.ex_redirect;
    assign run_stall    = resolve && !bus.ex_redirect && load_use;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_clear = 1'b0;
        idex_en    = 1'b1;
        idex_clear = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        if (rst || boot) begin
            pc_en      = 1'b0;
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
        end else if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (run_redirect) begin
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
        end else if (run_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_clear = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_memwait_q, perf_memwait_d;

    always_comb begin
        perf_stall_d   = perf_stall_q + {31'd0, run_stall};
        perf_flush_d   = perf_flush_q + {31'd0, run_redirect};
        perf_memwait_d = perf_memwait_q + {31'd0, freeze};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q   <= 32'd0;
            perf_flush_q   <= 32'd0;
            perf_memwait_q <= 32'd0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_memwait_q <= perf_memwait_d;
        end
    end

    assign bus.perf_stall   = perf_stall_q;
    assign bus.perf_flush   = perf_flush_q;
    assign bus.perf_memwait = perf_memwait_q;
`endif

    // With zero start-up bubbles, reset lands directly in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (RESET_BUBBLES == 0) ? RUN : BOOT;
            bub_cnt_q  <= BUB_INIT;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bub_cnt_q  <= bub_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.ifid_en    = ifid_en;
    assign bus.ifid_clear = ifid_clear;
    assign bus.idex_en    = idex_en;
    assign bus.idex_clear = idex_clear;
    assign bus.exmem_en   = exmem_en;
    assign bus.memwb_en   = memwb_en;
    assign bus.mem_err    = mem_err_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard testbench for pipe_hazard_ctrl (RESET_BUBBLES=2, MEM_TIMEOUT=4).
// Control vectors are packed as {pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, memwb_en}.
module tb_pipe_hazard_ctrl;
    localparam logic [6:0] C_BOOT   = 7'b0111111;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_FLUSH  = 7'b1111111;
    localparam logic [6:0] C_STALL  = 7'b0001111;
    localparam logic [6:0] C_NORM   = 7'b1101011;
    localparam int         TIMEOUT  = 4;

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
        logic [1:0] st;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    int   m_state, m_bub, m_wait;
    logic m_err;
    int   m_pstall, m_pflush, m_pwait;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.RESET_BUBBLES(2), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pop one expectation per cycle, away from the rising edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.tag, ".ctrl"}, 32'({bus.pc_en, bus.ifid_en, bus.ifid_clear, bus.idex_en,
                                               bus.idex_clear, bus.exmem_en, bus.memwb_en}), 32'(e.ctrl));
            checkOutput({e.tag, ".state"}, 32'(bus.state_o), 32'(e.st));
            checkOutput({e.tag, ".err"}, 32'(bus.mem_err), 32'(e.err));
        end
    end

    task automatic applyStimulus(input string tag, input logic r,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic mr,
                                 input logic [4:0] rd, input logic redir,
                                 input logic req, input logic rdy);
        exp_t e;
        logic hz;
        logic decide;
        int   n_state, n_bub, n_wait;
        logic n_err;
        rst = r;
        bus.id_rs1 = rs1;
        bus.id_rs2 = rs2;
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
        bus.ex_memread = mr;
        bus.ex_rd = rd;
        bus.ex_redirect = redir;
        bus.mem_req = req;
        bus.mem_ready = rdy;

        hz = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e.tag = tag;
        e.st = 2'(m_state);
        e.err = m_err;
        e.ctrl = C_NORM;
        decide = 1'b0;
        n_state = m_state;
        n_bub = m_bub;
        n_wait = m_wait;
        n_err = m_err;
        if (r) begin
            e.ctrl = C_BOOT;
            n_state = 0;
            n_bub = 2;
            n_wait = 0;
            n_err = 1'b0;
        end else if (m_state == 0) begin
            e.ctrl = C_BOOT;
            n_bub = m_bub - 1;
            if (m_bub <= 1) n_state = 1;
        end else if (m_state == 1) begin
            if (req && !rdy) begin
                e.ctrl = C_FREEZE;
                n_state = 2;
                n_wait = 1;
            end else begin
                decide = 1'b1;
            end
        end else begin
            if (!rdy) begin
                e.ctrl = C_FREEZE;
                if (m_wait == TIMEOUT) n_err = 1'b1;
                n_wait = (m_wait >= TIMEOUT) ? TIMEOUT : m_wait + 1;
            end else begin
                decide = 1'b1;
                n_state = 1;
                n_wait = 0;
            end
        end
        if (decide) begin
            if (redir)   e.ctrl = C_FLUSH;
            else if (hz) e.ctrl = C_STALL;
        end
        if (!r) begin
            if (e.ctrl == C_FREEZE && m_state != 0) m_pwait++;
            if (decide && redir) m_pflush++;
            if (decide && !redir && hz) m_pstall++;
        end else begin
            m_pwait = 0;
            m_pflush = 0;
            m_pstall = 0;
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        m_state = n_state;
        m_bub = n_bub;
        m_wait = n_wait;
        m_err = n_err;
    endtask

    task automatic idle(input string tag, input logic r);
        applyStimulus(tag, r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.id_rs1 = 5'd0;
        bus.id_rs2 = 5'd0;
        bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0;
        bus.ex_memread = 1'b0;
        bus.ex_rd = 5'd0;
        bus.ex_redirect = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_state = 0;
        m_bub = 2;
        m_wait = 0;
        m_err = 1'b0;
        m_pstall = 0;
        m_pflush = 0;
        m_pwait = 0;

        idle("reset", 1'b1);
        idle("boot0", 1'b0);
        idle("boot1", 1'b0);
        idle("run0", 1'b0);

        // load-use detection and its boundaries
        applyStimulus("lu_rs2", 0, 5'd3, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0);
        idle("lu_after", 1'b0);
        applyStimulus("lu_x0", 0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0);
        applyStimulus("lu_unused", 0, 5'd7, 5'd2, 0, 1, 1, 5'd7, 0, 0, 0);
        applyStimulus("lu_rs1", 0, 5'd7, 5'd2, 1, 0, 1, 5'd7, 0, 0, 0);
        applyStimulus("lu_noload", 0, 5'd7, 5'd7, 1, 1, 0, 5'd7, 0, 0, 0);

        // redirect, alone and over a load-use hazard
        applyStimulus("redir_lu", 0, 5'd3, 5'd5, 1, 1, 1, 5'd5, 1, 0, 0);
        applyStimulus("redir", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
        applyStimulus("req_ready", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
        applyStimulus("noreq", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);

        // three freeze cycles, then release
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("frz%0d", i), 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        applyStimulus("frz_rel", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
        idle("frz_done", 1'b0);

        // release cycle resolving a redirect, then a load-use
        applyStimulus("frz2", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        applyStimulus("frz2_redir", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1);
        applyStimulus("frz3", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        applyStimulus("frz3_lu", 0, 5'd9, 5'd1, 1, 0, 1, 5'd9, 0, 1, 1);

        // timeout: mem_err is sticky until reset
        for (int i = 0; i < 7; i++)
            applyStimulus($sformatf("tmo%0d", i), 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        applyStimulus("tmo_rel", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
        idle("tmo_sticky0", 1'b0);
        idle("tmo_sticky1", 1'b0);

`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_stall", bus.perf_stall, 32'(m_pstall));
        checkOutput("perf_flush", bus.perf_flush, 32'(m_pflush));
        checkOutput("perf_memwait", bus.perf_memwait, 32'(m_pwait));
`endif

        idle("rst2", 1'b1);
        idle("rst2_boot0", 1'b0);
        idle("rst2_boot1", 1'b0);
        idle("rst2_run", 1'b0);

`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_stall_rst", bus.perf_stall, 32'd0);
        checkOutput("perf_memwait_rst", bus.perf_memwait, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
